// File: rtl/color_gen.sv
// LFSR-driven red/green/blue sequence generator; first color valid one cycle after start.
// Valid/ready output: color, last and the LFSR hold while ready is low; back-to-back beats allowed.
module color_gen #(
    parameter int         LEN_W    = 8,
    parameter logic [7:0] SEED_DEF = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             seed_load,
    input  logic [7:0]       seed,
    output logic [1:0]       color,
    output logic             valid,
    input  logic             ready,
    output logic             last,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [1:0]       color_q, color_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [7:0]       seed_eff;
    logic [7:0]       lfsr_base;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [1:0] first_color(input logic [7:0] l);
        return (l[1:0] == 2'd3) ? 2'd0 : l[1:0];
    endfunction

    // (prev + 1 + bit) mod 3; the step is always 1 or 2 so neighbours never match
    function automatic logic [1:0] next_color(input logic [1:0] prev, input logic b);
        logic [2:0] s;
        s = {1'b0, prev} + 3'd1 + {2'b00, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by the default
    assign seed_eff  = (seed == 8'h00) ? SEED_DEF : seed;
    assign lfsr_base = seed_load ? seed_eff : lfsr_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        color_d = color_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = seed_eff;
                end
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        color_d = first_color(lfsr_base);
                        lfsr_d  = lfsr_adv(lfsr_base);
                        cnt_d   = len;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ready) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        color_d = next_color(color_q, lfsr_q[0]);
                        lfsr_d  = lfsr_adv(lfsr_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_DEF;
            color_q <= 2'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            color_q <= color_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign valid = (state_q == RUN);
    assign busy  = (state_q == RUN);
    assign last  = valid & (cnt_q == LEN_W'(1));
    assign color = color_q;
    assign done  = done_q;

endmodule

// File: tb/tb_color_gen.sv
// Randomized scoreboard bench for color_gen against a sequence-level reference model.
module tb_color_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       seed_load;
    logic [7:0] seed;
    logic [1:0] color;
    logic       valid;
    logic       ready;
    logic       last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // model state
    int   exp_q[$];
    int   cap[$];
    int   m_rem = 0;
    int   ml = 8'hA5;
    int   done_exp = 0;
    int   xfers = 0;
    int   rdy_mode = 0;

    color_gen #(.LEN_W(8), .SEED_DEF(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .seed_load(seed_load), .seed(seed), .color(color), .valid(valid),
        .ready(ready), .last(last), .busy(busy), .done(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int adv(input int l);
        int b7, b5, b4, b3;
        b7 = (l / 128) % 2; b5 = (l / 32) % 2; b4 = (l / 16) % 2; b3 = (l / 8) % 2;
        return ((l * 2) % 256) + ((b7 + b5 + b4 + b3) % 2);
    endfunction

    // Expected colors for a sequence of n beats, starting from the model LFSR
    task automatic gen(input int n);
        int l, c;
        l = ml;
        c = l % 4;
        if (c == 3) c = 0;
        exp_q.push_back(c);
        l = adv(l);
        for (int i = 1; i < n; i++) begin
            c = (c + 1 + (l % 2)) % 3;
            exp_q.push_back(c);
            l = adv(l);
        end
        ml = l;
    endtask

    // Ready generator
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        int nd, prev_col, first_beat, got;
        prev_col = 0;
        first_beat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rem = 0;
                ml = 8'hA5;
                exp_q.delete();
                done_exp = 0;
            end else begin
                chk("valid", int'(valid), int'(m_rem != 0));
                chk("busy", int'(busy), int'(m_rem != 0));
                chk("done", int'(done), done_exp);
                nd = 0;
                if (m_rem != 0) begin
                    chk("color", int'(color), exp_q[0]);
                    chk("last", int'(last), int'(m_rem == 1));
                    chk("color_not_3", int'(color != 2'd3), 1);
                    if (ready) begin
                        got = exp_q.pop_front();
                        if (!first_beat) chk("adjacent_differ", int'(int'(color) != prev_col), 1);
                        prev_col = int'(color);
                        first_beat = 0;
                        cap.push_back(int'(color));
                        xfers++;
                        m_rem--;
                        if (m_rem == 0) nd = 1;
                    end
                end else begin
                    if (seed_load) ml = (seed == 8'h00) ? 8'hA5 : int'(seed);
                    if (start) begin
                        if (len == 8'd0) nd = 1;
                        else begin
                            gen(int'(len));
                            m_rem = int'(len);
                            first_beat = 1;
                        end
                    end
                end
                done_exp = nd;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int l, input bit sl, input int sd);
        start = 1'b1; len = 8'(l); seed_load = sl; seed = 8'(sd);
        cyc(1);
        start = 1'b0; seed_load = 1'b0;
    endtask

    task automatic load_seed(input int sd);
        seed_load = 1'b1; seed = 8'(sd);
        cyc(1);
        seed_load = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_rem != 0 || busy) && n < budget) begin
            cyc(1);
            n++;
        end
        if (n >= budget) chk("wait_idle_timeout", 1, 0);
        cyc(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic expect_seq(input string name, input int base, input int a, input int b, input int c, input int n);
        int tbl[3];
        tbl[0] = a; tbl[1] = b; tbl[2] = c;
        chk({name, "_count"}, cap.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < cap.size()) chk(name, cap[base + i], tbl[i]);
    endtask

    initial begin
        int base, x0, l, sd;
        rst_n = 1'b0; start = 1'b0; len = 8'd0; seed_load = 1'b0; seed = 8'd0;
        #2;
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_color", int'(color), 0);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(2);

        // basic sequence from default seed
        rdy_mode = 0;
        base = cap.size(); x0 = xfers;
        start_seq(3, 0, 0);
        wait_idle(100);
        expect_seq("basic_seq", base, 1, 2, 1, 3);

        // same with a 4-cycle stall on the second beat
        do_reset();
        base = cap.size();
        start_seq(3, 0, 0);
        cyc(1);
        rdy_mode = 2;
        cyc(4);
        rdy_mode = 0;
        wait_idle(100);
        expect_seq("stall_seq", base, 1, 2, 1, 3);

        // zero seed substitutes the default
        load_seed(0);
        base = cap.size();
        start_seq(3, 0, 0);
        wait_idle(100);
        expect_seq("seed0_seq", base, 1, 2, 1, 3);

        // seed 3 remaps first color to 0
        load_seed(8'h03);
        base = cap.size();
        start_seq(1, 0, 0);
        wait_idle(100);
        expect_seq("seed3_seq", base, 0, 0, 0, 1);

        // seed_load together with start
        base = cap.size();
        start_seq(1, 1, 8'h03);
        wait_idle(100);
        expect_seq("seed3_same_cycle", base, 0, 0, 0, 1);

        // zero length: done only
        base = cap.size();
        start_seq(0, 0, 0);
        cyc(4);
        chk("len0_no_colors", cap.size() - base, 0);

        // full-length run with random ready and an ignored restart
        rdy_mode = 1;
        x0 = xfers;
        start_seq(255, 1, int'($urandom_range(0, 255)));
        cyc(20);
        start_seq(5, 1, 8'h11);
        wait_idle(3000);
        chk("len255_xfers", xfers - x0, 255);

        // random sequences
        for (int k = 0; k < 6; k++) begin
            l = int'($urandom_range(1, 20));
            sd = int'($urandom_range(0, 255));
            x0 = xfers;
            start_seq(l, 1'($urandom_range(0, 1)), sd);
            wait_idle(500);
            chk("rand_xfers", xfers - x0, l);
        end

        // reset mid-sequence
        rdy_mode = 0;
        start_seq(10, 0, 0);
        cyc(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_last", int'(last), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_color", int'(color), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(3);
        base = cap.size();
        start_seq(3, 0, 0);
        wait_idle(100);
        expect_seq("post_rst_seq", base, 1, 2, 1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_gen.md
COLOR_GEN -- requirements
Module: color_gen

Interface
REQ-001 Parameter LEN_W, default 8, sets the width of the sequence-length input and the internal beat counter.
REQ-002 Parameter SEED_DEF, default 8'hA5, is the LFSR reset value and the substitute for a zero seed.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a sequence of len colors.
REQ-006 len  input  LEN_W  number of colors to emit, sampled with start.
REQ-007 seed_load  input  1  load seed into LFSR.
REQ-008 seed  input  8  LFSR load value.
REQ-009 color  output  2  emitted color: 0 red, 1 green, 2 blue; 3 never emitted.
REQ-010 valid  output  1  color is valid.
REQ-011 ready  input  1  consumer (color checker) accepts the current color.
REQ-012 last  output  1  current color is the final beat of the sequence.
REQ-013 busy  output  1  sequence in progress.
REQ-014 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-015 FSM SHALL have two states: IDLE (busy=0, valid=0) and RUN (busy=1, valid=1).
REQ-016 LFSR SHALL be 8-bit Fibonacci: fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}.
REQ-017 "Load a color" SHALL mean: register the new color, then advance the LFSR once in the same cycle.
REQ-018 First color SHALL be l[1:0], except that l[1:0]==3 maps to 0.
REQ-019 Each subsequent color SHALL be (prev + 1 + l[0]) mod 3, so adjacent colors always differ.
REQ-020 IDLE with start=1 and len!=0: load first color, counter = len, go to RUN; valid rises the next cycle (1-cycle latency).
REQ-021 IDLE with start=1 and len==0: stay in IDLE, emit no color, pulse done the next cycle.
REQ-022 A transfer SHALL occur when valid&ready is high at a rising edge.
REQ-023 While valid=1 and ready=0, color, last and the LFSR SHALL hold unchanged.
REQ-024 RUN, transfer with counter>1: counter decrements and the next color is loaded; valid stays high, with back-to-back transfers allowed every cycle.
REQ-025 RUN, transfer with counter==1: go to IDLE, no color load, no LFSR advance; done=1 for exactly the next cycle.
REQ-026 last SHALL equal valid & (counter==1).
REQ-027 start SHALL be ignored while busy=1.
REQ-028 seed_load SHALL take effect in IDLE only; seed==0 loads SEED_DEF instead, so the LFSR is never zero.
REQ-029 If seed_load and start are high together in IDLE, the seed SHALL load first and the first color SHALL come from the loaded seed value.
REQ-030 seed_load SHALL be ignored in RUN.
REQ-031 The counter SHALL not wrap; len = 2^LEN_W-1 emits exactly that many colors.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, valid=0, last=0, busy=0, done=0, color=0, counter=0, LFSR=SEED_DEF.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no done pulse; after release the block waits in IDLE for start.
REQ-034 The first color after reset SHALL depend only on SEED_DEF and any later seed_load.

Verification
REQ-035 Reset, start=1, len=3, ready=1 -> colors 1,2,1 on consecutive cycles; last on the third color; done one cycle later.
REQ-036 Same as REQ-035 with ready low for 4 cycles during the second beat -> color 2 held stable, sequence still 1,2,1, LFSR unchanged while stalled.
REQ-037 seed_load=1, seed=0 -> LFSR=A5; seed_load with seed=8'h03 then start, len=1 -> color 0 (remap of 3), last=1, done follows.
REQ-038 start, len=0 -> valid never rises; done pulses the next cycle.
REQ-039 len=255, random ready -> exactly 255 transfers; no adjacent equal colors; color never 3; second start during RUN ignored.
REQ-040 rst_n low mid-sequence -> all outputs 0 asynchronously, no done pulse; a new start after release reproduces the REQ-035 sequence.
